// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   state_e    : access FSM states
//   F3_*       : funct3 access size/sign encodings
//   be_t       : 4-bit byte-enable vector
//   f3_illegal : funct3 legality check for a given direction
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [3:0] be_t;

  // Stores only have signed-size encodings; unsigned forms are load-only.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return !(f3 inside {F3_B, F3_H, F3_W}) && (we || !(f3 inside {F3_BU, F3_HU}));
  endfunction
endpackage

// File: rtl/lsu_if.sv
// Valid/ready data bus between the load/store unit (master) and memory (slave).
//   valid/ready : request handshake; we/addr/be/wdata are request fields
//   rvalid/rdata: load response
interface lsu_if import lsu_pkg::*; #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  be_t               be;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output valid, we, addr, be, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, be, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   f3    : funct3 of the access      alo   : address bits [1:0]
//   wdata : store data (rs2)          rdata : raw bus word for loads
//   be    : byte enables              wrep  : lane-replicated store data
//   rext  : shifted and sign/zero-extended load data
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  f3,
  input  logic [1:0]  alo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output be_t         be,
  output logic [31:0] wrep,
  output logic [31:0] rext
);
  logic [31:0] sh;

  always_comb begin
    be   = 4'b1111;
    wrep = wdata;
    case (f3[1:0])
      2'b00: begin
        be   = 4'b0001 << alo;
        wrep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << {alo[1], 1'b0};
        wrep = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    sh = rdata >> {alo, 3'b000};
    case (f3)
      F3_B:    rext = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   rext = {24'h0, sh[7:0]};
      F3_H:    rext = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   rext = {16'h0, sh[15:0]};
      default: rext = sh;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: bridges the single-cycle core's memory access onto a
// valid/ready bus, stalling the core until the access completes.
// Ports:
//   clk, reset (async, active low)
//   mem_req, memwrite, funct3, addr, wdata : core request
//   readdata, done, misalign, access_err   : completion, valid while done=1
//   stall                                  : hold the core
//   bus (lsu_if.master)                    : data bus
// Parameters: TIMEOUT (0 = never), ADDR_W.
// Build option: MISALIGN_TRAP_EN traps misaligned H/W accesses instead of
// masking the low address bits.
module load_store_unit import lsu_pkg::*; #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       readdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic              access_err,
  lsu_if.master             bus
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              we_q, err_q, mis_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q, addr_m;
  logic [31:0]       wdata_q, rdata_q;
  logic              mis_in, tmo, req_vld, cap, set_err, set_mis;
  be_t               be;
  logic [31:0]       wrep, rext;

  // Misaligned H/W: either trapped, or the low bits are dropped.
  always_comb begin
    addr_m = addr;
    mis_in = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_in = (funct3[1:0] == 2'b01 && addr[0]) ||
             (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    if (funct3[1:0] == 2'b01) addr_m[0]   = 1'b0;
    if (funct3[1:0] == 2'b10) addr_m[1:0] = 2'b00;
`endif
  end

  assign tmo = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req_vld  = 1'b0;
    cap      = 1'b0;
    set_err  = 1'b0;
    set_mis  = 1'b0;
    case (state)
      IDLE: if (mem_req) begin
        if (f3_illegal(funct3, memwrite)) begin
          state_nx = DONE;
          set_err  = 1'b1;
        end else if (mis_in) begin
          state_nx = DONE;
          set_mis  = 1'b1;
        end else begin
          state_nx = REQ;
        end
      end
      REQ: if (tmo) begin
        state_nx = DONE;
        set_err  = 1'b1;
      end else begin
        req_vld = 1'b1;
        if (bus.ready) begin
          if (we_q) begin
            state_nx = DONE;
          end else if (bus.rvalid) begin
            state_nx = DONE;   // zero-wait response
            cap      = 1'b1;
          end else begin
            state_nx = RSP;
          end
        end
      end
      RSP: if (tmo) begin
        state_nx = DONE;
        set_err  = 1'b1;
      end else if (bus.rvalid) begin
        state_nx = DONE;
        cap      = 1'b1;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Error/misalign flags are set only on the edge into DONE, so they are
  // high exactly for the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      err_q <= set_err;
      mis_q <= set_mis;
      if (state == IDLE && mem_req) begin
        we_q    <= memwrite;
        f3_q    <= funct3;
        addr_q  <= addr_m;
        wdata_q <= wdata;
      end
      if (state == IDLE && state_nx == REQ) cnt <= '0;
      else if (state == REQ || state == RSP) cnt <= cnt + 1'b1;
      if (cap) rdata_q <= bus.rdata;
    end
  end

  lsu_align u_align (
    .f3    (f3_q),
    .alo   (addr_q[1:0]),
    .wdata (wdata_q),
    .rdata (rdata_q),
    .be    (be),
    .wrep  (wrep),
    .rext  (rext)
  );

  assign bus.valid = req_vld;
  assign bus.we    = req_vld & we_q;
  assign bus.addr  = req_vld ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.be    = req_vld ? be : '0;
  assign bus.wdata = (req_vld && we_q) ? wrep : '0;

  assign done       = (state == DONE);
  assign stall      = mem_req & (state != DONE);
  assign access_err = done & err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign   = done & mis_q;
`else
  assign misalign   = 1'b0;
`endif
  assign readdata   = (done && !we_q && !err_q && !mis_q) ? rext : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// accesses checked cycle by cycle against a transaction-level model.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req = 1'b0, memwrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] readdata;
  logic        stall, done, misalign, access_err;

  lsu_if #(.ADDR_W(32)) bus();

  load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .readdata   (readdata),
    .stall      (stall),
    .done       (done),
    .misalign   (misalign),
    .access_err (access_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One access. rdly: cycles into the request before ready; vdly: cycles
  // after acceptance before rvalid (0 = same cycle). Cycle 0 is the IDLE
  // cycle in which mem_req first appears.
  task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int rdly, input int vdly,
                        input logic [31:0] rd, input bit stray);
    int s, dcyc, vend, lat;
    bit lg, mis, trap, tmo, bv;
    logic [31:0] ea, ebe, ewd, erd, m;

    s  = 1 << f3[1:0];
    lg = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!we && (f3 == 3'd4 || f3 == 3'd5)));
    ea = a - (a % s);
`ifdef MISALIGN_TRAP_EN
    mis  = lg && (a % s != 0);
    trap = !lg || mis;
`else
    mis  = 1'b0;
    trap = !lg;
`endif
    tmo = 1'b0;
    if (trap) begin
      dcyc = 1; vend = 0;
    end else begin
      lat = we ? rdly : rdly + vdly;
      tmo = (lat >= TO);
      if (tmo) begin
        dcyc = TO + 2;
        vend = (rdly < TO) ? 1 + rdly : TO;
      end else begin
        dcyc = 2 + lat;
        vend = 1 + rdly;
      end
    end

    ebe = ((32'd1 << s) - 1) << (ea % 4);
    ewd = (s == 1) ? wd[7:0] * 32'h01010101 : (s == 2) ? wd[15:0] * 32'h00010001 : wd;
    erd = rd >> (8 * (ea % 4));
    if (s < 4) begin
      m   = (32'd1 << (8 * s)) - 1;
      erd = erd & m;
      if (f3 < 3'd4 && erd[8*s-1]) erd = erd | ~m;
    end
    if (trap || tmo) erd = 32'h0;

    mem_req  = 1'b1;
    memwrite = we;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    for (int c = 0; c <= dcyc; c++) begin
      @(negedge clk);
      bv = (c >= 1 && c <= vend);
      chk("stall", stall, c != dcyc);
      chk("done", done, c == dcyc);
      chk("bus_valid", bus.valid, bv);
      if (bv) begin
        chk("bus_addr", bus.addr, {a[31:2], 2'b00});
        chk("bus_be", bus.be, ebe);
        chk("bus_we", bus.we, we);
        if (we) chk("bus_wdata", bus.wdata, ewd);
      end
      if (c == dcyc) begin
        if (!we) chk("readdata", readdata, erd);
        chk("access_err", access_err, !lg || tmo);
        chk("misalign", misalign, mis);
      end else begin
        chk("readdata_idle", readdata, 32'h0);
        chk("err_idle", access_err, 1'b0);
        chk("mis_idle", misalign, 1'b0);
      end
      bus.ready  = (c == 1 + rdly);
      bus.rvalid = (!we && c == 1 + rdly + vdly) || (stray && (c == 0 || c == dcyc));
      bus.rdata  = (c == 1 + rdly + vdly) ? rd : $urandom;
    end
    @(posedge clk); #1;
    mem_req    = 1'b0;
    bus.ready  = 1'b0;
    bus.rvalid = 1'b0;
    @(negedge clk);
    chk("gap_stall", stall, 1'b0);
    chk("gap_done", done, 1'b0);
    chk("gap_valid", bus.valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.ready  = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;

    // Reset state.
    #12;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_be", bus.be, 4'h0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_err", access_err, 1'b0);
    chk("rst_mis", misalign, 1'b0);
    mem_req = 1'b1;
    #1 chk("rst_stall_req", stall, 1'b1);
    mem_req = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    bus.rvalid = 1'b1;        // stray response right after reset
    bus.rdata  = 32'h12345678;
    repeat (2) begin
      @(negedge clk);
      chk("stray_done", done, 1'b0);
      chk("stray_valid", bus.valid, 1'b0);
    end
    bus.rvalid = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op(1, 3'd2, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0, 0);        // SW
    run_op(0, 3'd0, 32'h203, 32'h0, 0, 1, 32'h80112233, 0);        // LB
    run_op(0, 3'd4, 32'h203, 32'h0, 0, 1, 32'h80112233, 0);        // LBU
    run_op(0, 3'd1, 32'h202, 32'h0, 0, 0, 32'h7FFF0000, 0);        // LH zero-wait
    run_op(0, 3'd2, 32'h102, 32'h0, 0, 0, 32'hCAFEF00D, 0);        // LW misaligned
    run_op(1, 3'd1, 32'h203, 32'h0000A5C3, 0, 0, 32'h0, 0);        // SH misaligned
    run_op(1, 3'd0, 32'h040, 32'h11223344, 99, 0, 32'h0, 0);       // timeout
    run_op(0, 3'd5, 32'h042, 32'h0, 1, 99, 32'h0, 0);              // response timeout
    run_op(0, 3'd3, 32'h044, 32'h0, 0, 0, 32'h0, 1);               // illegal funct3
    run_op(1, 3'd4, 32'h045, 32'hFF, 0, 0, 32'h0, 1);              // unsigned store

    // Reset while waiting for the response; a late rvalid must be ignored.
    mem_req  = 1'b1;
    memwrite = 1'b0;
    funct3   = 3'd2;
    addr     = 32'h300;
    @(negedge clk);                       // IDLE
    @(negedge clk);                       // REQ
    chk("rsp_rst_req", bus.valid, 1'b1);
    bus.ready = 1'b1;
    @(negedge clk);                       // RSP
    bus.ready = 1'b0;
    chk("rsp_rst_wait", bus.valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("rsp_rst_valid", bus.valid, 1'b0);
    chk("rsp_rst_stall", stall, 1'b1);
    chk("rsp_rst_done", done, 1'b0);
    mem_req    = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rsp_rst_ign_done", done, 1'b0);
      chk("rsp_rst_ign_valid", bus.valid, 1'b0);
      chk("rsp_rst_ign_rd", readdata, 32'h0);
    end
    bus.rvalid = 1'b0;
    @(posedge clk); #1;
    run_op(0, 3'd0, 32'h301, 32'h0, 0, 0, 32'h0000AA00, 0);         // back in IDLE

    // Random accesses.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] f3r;
      int rd_d, vd_d;
      f3r  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2) + ($urandom_range(0, 1) * 4))
                                        : 3'($urandom_range(0, 7));
      rd_d = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 2) : $urandom_range(3, 6);
      vd_d = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 2) : $urandom_range(3, 6);
      run_op(1'($urandom_range(0, 1)), f3r, $urandom, $urandom, rd_d, vd_d, $urandom,
             1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
